// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the issue
// handshake toward decode/execute and the redirect/fault sideband.
interface fetch_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;
  logic                issue_valid;
  logic                issue_ready;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pc;
  logic [10:0]         ctrl_addr;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                fetch_fault;

  modport master (
    output imem_req, imem_addr, issue_valid, instr, pc, ctrl_addr, fetch_fault,
    input  imem_rvalid, imem_rdata, issue_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid, instr, pc, ctrl_addr, fetch_fault,
    output imem_rvalid, imem_rdata, issue_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch for the non-pipelined RV32 core: one outstanding fetch,
// held instruction issued with its control-ROM address, sticky fault on timeout.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         MAX_WAIT = 16
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {REQ, WAIT, ISSUE, FAULT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t              state, state_n;
  logic [7:0]          wait_cnt, wait_cnt_n;
  logic [PC_WIDTH-1:0] pc_p0, pc_n;
  logic [31:0]         instr_p0, instr_n;
  logic                issue_valid;
  logic                misaligned;

  assign misaligned = bus.redirect_pc[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      wait_cnt <= '0;
      pc_p0    <= RESET_PC;
      instr_p0 <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      pc_p0    <= pc_n;
      instr_p0 <= instr_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    pc_n       = pc_p0;
    instr_n    = instr_p0;
    unique case (state)
      REQ: begin
        wait_cnt_n = '0;
        state_n    = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_n = bus.imem_rdata;
          state_n = ISSUE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = FAULT;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      ISSUE: begin
        // Redirect is only honoured on the handshake; a bad target faults
        // without disturbing the PC of the instruction that requested it.
        if (bus.issue_ready) begin
          if (bus.redirect_valid && misaligned) begin
            state_n = FAULT;
          end else begin
            pc_n    = bus.redirect_valid ? bus.redirect_pc : pc_p0 + PC_WIDTH'(4);
            state_n = REQ;
          end
        end
      end
      FAULT: state_n = FAULT;
      default: state_n = REQ;
    endcase
  end

  // Output stage: decoded from the held state, all forced low during reset.
  assign issue_valid     = !reset && (state == ISSUE);
  assign bus.issue_valid = issue_valid;
  assign bus.imem_req    = !reset && (state == REQ);
  assign bus.imem_addr   = (!reset && state == REQ) ? pc_p0 : '0;
  assign bus.instr       = issue_valid ? instr_p0 : '0;
  assign bus.ctrl_addr   = issue_valid ? {instr_p0[30], instr_p0[14:12], instr_p0[6:0]} : '0;
  assign bus.pc          = reset ? '0 : pc_p0;
  assign bus.fetch_fault = !reset && (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder driven step by step, with
// expected issues queued on response and compared when the DUT issues them.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_if #(.PC_WIDTH(32)) bus ();

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .MAX_WAIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [10:0] last_ctrl;

  function automatic logic [10:0] ctrl_of(input logic [31:0] i);
    return {i[30], i[14:12], i[6:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.issue_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b0;
    repeat (2) begin
      step();
      chk("rst_req", {bus.imem_req, bus.issue_valid, bus.fetch_fault}, 0);
      chk("rst_addr_pc", {bus.imem_addr, bus.pc}, 0);
      chk("rst_instr_ctrl", {bus.instr, bus.ctrl_addr}, 0);
    end
    reset = 1'b0;
    #1;
    sb.delete();
    exp_pc = 32'h0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("req_seen", bus.imem_req, 1);
    chk("req_addr", bus.imem_addr, exp_pc);
  endtask

  task automatic fetch(input int lat, input logic [31:0] data, input int stall,
                       input logic rv, input logic [31:0] rpc, input logic junk_req,
                       input logic pulse_redir, input logic pulse_rvalid);
    exp_t e;
    wait_req();
    if (junk_req) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0BAD;
    end
    step();
    bus.imem_rvalid = 1'b0;
    chk("wait_no_issue", bus.issue_valid, 0);
    for (int k = 1; k < lat; k++) step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    sb.push_back('{instr: data, pc: exp_pc});
    step();
    bus.imem_rvalid = 1'b0;
    chk("issue_valid", bus.issue_valid, 1);
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("issue_instr", bus.instr, e.instr);
      chk("issue_pc", bus.pc, e.pc);
      chk("issue_ctrl", bus.ctrl_addr, ctrl_of(e.instr));
      last_ctrl = bus.ctrl_addr;
      for (int s = 0; s < stall; s++) begin
        bus.issue_ready = 1'b0;
        if (pulse_redir && s == 0) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = 32'h200;
        end
        if (pulse_rvalid && s == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b0;
        chk("stall_valid", bus.issue_valid, 1);
        chk("stall_instr", bus.instr, e.instr);
        chk("stall_pc", bus.pc, e.pc);
        chk("stall_no_req", bus.imem_req, 0);
      end
    end
    bus.issue_ready    = 1'b1;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    step();
    bus.issue_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    if (rv) begin
      if (rpc[1:0] == 2'b00) exp_pc = rpc;
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.issue_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    exp_pc = '0;
    last_ctrl = '0;

    // Reset release, latency 1, sub instruction.
    do_reset();
    fetch(1, 32'h4000_0433, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_ctrl", last_ctrl, 11'h433);
    wait_req();

    // Four sequential instructions, latency 3, two stall cycles each.
    do_reset();
    for (int i = 0; i < 4; i++)
      fetch(3, 32'h0010_0093 + (i << 20), 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Taken branch to 0x100, then an ignored redirect pulse while stalled.
    fetch(1, 32'h0020_8063, 1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("t3_ctrl", last_ctrl, 11'h063);
    fetch(1, 32'h0000_0013, 2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("after_ignored_redirect", exp_pc, 32'h104);

    // Response on the last allowed WAIT cycle, then rvalid during REQ dropped.
    fetch(16, 32'h0041_8193, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("late_resp_no_fault", bus.fetch_fault, 0);
    fetch(2, 32'h0052_0213, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // PC wrap at the top of the address space; rvalid in ISSUE ignored.
    fetch(1, 32'h0000_006F, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    fetch(1, 32'h0063_02B3, 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("wrap_exp", exp_pc, 32'h0);
    wait_req();

    // Reset during WAIT: restart at RESET_PC, stale rvalid in REQ dropped.
    step();
    step();
    reset = 1'b1;
    step();
    chk("midwait_rst_out", {bus.imem_req, bus.issue_valid, bus.fetch_fault}, 0);
    reset = 1'b0;
    #1;
    sb.delete();
    exp_pc = 32'h0;
    fetch(2, 32'h0000_0033, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect: sticky fault, no requests, pc held.
    fetch(1, 32'h0000_0063, 0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
    chk("mis_fault", bus.fetch_fault, 1);
    chk("mis_pc_held", bus.pc, 32'h4);
    chk("mis_outs", {bus.issue_valid, bus.instr, bus.ctrl_addr}, 0);
    repeat (20) begin
      step();
      chk("fault_no_req", bus.imem_req, 0);
      chk("fault_sticky", bus.fetch_fault, 1);
    end
    do_reset();
    chk("fault_cleared", bus.fetch_fault, 0);
    wait_req();

    // Memory never answers: fault after exactly 16 WAIT cycles.
    repeat (16) begin
      step();
      chk("timeout_pending", bus.fetch_fault, 0);
    end
    step();
    chk("timeout_fault", bus.fetch_fault, 1);
    do_reset();
    wait_req();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
